// File: rtl/pc_update_ctrl.sv
// PC update sequencer: arbitrates fetch/branch/jump/rte into PC source select and write strobes.
// Exception entry sequence (save EPC, read vector into MDR, load PC) is built when PC_UPDATE_EXC_EN is defined.
module pc_update_ctrl #(
  parameter int unsigned MEM_WAIT   = 2,
  parameter logic [31:0] VEC_OPCODE = 32'd253,
  parameter logic [31:0] VEC_OVF    = 32'd254,
  parameter logic [31:0] VEC_DIV0   = 32'd255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_done,
  input  logic        branch_req,
  input  logic        branch_taken,
  input  logic        jump_req,
  input  logic        rte_req,
  input  logic [2:0]  exc_req,
  output logic [2:0]  pc_source_sel,
  output logic        pc_write,
  output logic        epc_write,
  output logic        mem_rd,
  output logic [31:0] exc_vec_addr,
  output logic        mdr_write,
  output logic [1:0]  exc_cause,
  output logic        busy
);

  localparam logic [2:0] SEL_PC4 = 3'b000;
  localparam logic [2:0] SEL_ALU = 3'b001;
  localparam logic [2:0] SEL_JMP = 3'b010;
  localparam logic [2:0] SEL_MDR = 3'b011;
  localparam logic [2:0] SEL_EPC = 3'b100;

  logic [2:0] pc_source_sel_d, pc_source_sel_q;
  logic       pc_write_d, pc_write_q;

  // Ordinary request arbitration, consulted only while idle.
  logic       req_write;
  logic [2:0] req_sel;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    req_write = 1'b1;
    req_sel   = SEL_PC4;
    if (rte_req)                      req_sel = SEL_EPC;
    else if (jump_req)                req_sel = SEL_JMP;
    else if (branch_req && branch_taken) req_sel = SEL_ALU;
    else if (fetch_done)              req_sel = SEL_PC4;
    else                              req_write = 1'b0;
  end

`ifdef PC_UPDATE_EXC_EN

  typedef enum logic [2:0] {
    IDLE,
    EXC_SAVE,
    EXC_READ,
    EXC_LOAD,
    EXC_JUMP
  } state_t;

  state_t      state_d, state_q;
  logic [3:0]  cnt_d, cnt_q;
  logic        epc_write_d, epc_write_q;
  logic        mem_rd_d, mem_rd_q;
  logic        mdr_write_d, mdr_write_q;
  logic        busy_d, busy_q;
  logic [31:0] exc_vec_addr_d, exc_vec_addr_q;
  logic [1:0]  exc_cause_d, exc_cause_q;
  logic [31:0] vec_addr;

  always_comb begin
    case (exc_cause_q)
      2'd0:    vec_addr = VEC_OPCODE;
      2'd1:    vec_addr = VEC_OVF;
      default: vec_addr = VEC_DIV0;
    endcase
  end

  // Outputs are registered, so each branch computes the values for the state being entered.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    exc_cause_d     = exc_cause_q;
    pc_source_sel_d = SEL_PC4;
    pc_write_d      = 1'b0;
    epc_write_d     = 1'b0;
    mem_rd_d        = 1'b0;
    mdr_write_d     = 1'b0;
    busy_d          = 1'b0;
    exc_vec_addr_d  = '0;
    case (state_q)
      IDLE: begin
        if (exc_req != 3'b000) begin
          state_d     = EXC_SAVE;
          epc_write_d = 1'b1;
          busy_d      = 1'b1;
          if (exc_req[0])      exc_cause_d = 2'd0;
          else if (exc_req[1]) exc_cause_d = 2'd1;
          else                 exc_cause_d = 2'd2;
        end else begin
          pc_write_d      = req_write;
          pc_source_sel_d = req_write ? req_sel : SEL_PC4;
        end
      end
      EXC_SAVE: begin
        state_d        = EXC_READ;
        cnt_d          = '0;
        mem_rd_d       = 1'b1;
        exc_vec_addr_d = vec_addr;
        busy_d         = 1'b1;
      end
      EXC_READ: begin
        busy_d = 1'b1;
        if (cnt_q == 4'(MEM_WAIT - 1)) begin
          state_d     = EXC_LOAD;
          mdr_write_d = 1'b1;
        end else begin
          cnt_d          = cnt_q + 4'd1;
          mem_rd_d       = 1'b1;
          exc_vec_addr_d = vec_addr;
        end
      end
      EXC_LOAD: begin
        state_d         = EXC_JUMP;
        pc_write_d      = 1'b1;
        pc_source_sel_d = SEL_MDR;
        busy_d          = 1'b1;
      end
      EXC_JUMP: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      pc_source_sel_q <= SEL_PC4;
      pc_write_q      <= 1'b0;
      epc_write_q     <= 1'b0;
      mem_rd_q        <= 1'b0;
      mdr_write_q     <= 1'b0;
      busy_q          <= 1'b0;
      exc_vec_addr_q  <= '0;
      exc_cause_q     <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pc_source_sel_q <= pc_source_sel_d;
      pc_write_q      <= pc_write_d;
      epc_write_q     <= epc_write_d;
      mem_rd_q        <= mem_rd_d;
      mdr_write_q     <= mdr_write_d;
      busy_q          <= busy_d;
      exc_vec_addr_q  <= exc_vec_addr_d;
      exc_cause_q     <= exc_cause_d;
    end
  end

  assign epc_write    = epc_write_q;
  assign mem_rd       = mem_rd_q;
  assign mdr_write    = mdr_write_q;
  assign busy         = busy_q;
  assign exc_vec_addr = exc_vec_addr_q;
  assign exc_cause    = exc_cause_q;

`else

  // Without the exception path the block is a single-cycle request register.
  logic unused_exc_req;
  assign unused_exc_req = ^exc_req;

  always_comb begin
    pc_write_d      = req_write;
    pc_source_sel_d = req_write ? req_sel : SEL_PC4;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_source_sel_q <= SEL_PC4;
      pc_write_q      <= 1'b0;
    end else begin
      pc_source_sel_q <= pc_source_sel_d;
      pc_write_q      <= pc_write_d;
    end
  end

  assign epc_write    = 1'b0;
  assign mem_rd       = 1'b0;
  assign mdr_write    = 1'b0;
  assign busy         = 1'b0;
  assign exc_vec_addr = '0;
  assign exc_cause    = '0;

`endif

  assign pc_source_sel = pc_source_sel_q;
  assign pc_write      = pc_write_q;

endmodule

// File: doc/pc_update_ctrl.md
# pc_update_ctrl

Sequencer for the program-counter update path of the multicycle core. Drives the 3-bit PC source select and the PC/EPC/MDR write strobes, arbitrating between sequential fetch, branch, jump, return-from-exception and exception entry. Exception entry is a multi-cycle sequence: save EPC, read the exception vector byte from memory into MDR, then load PC from MDR. Sits between the main control FSM and the PC source mux, PC, EPC and MDR registers.

## Interface
- MEM_WAIT, 2: cycles mem_rd is held for a vector read (1..15)
- VEC_OPCODE, 32'd253: vector address, invalid opcode
- VEC_OVF, 32'd254: vector address, arithmetic overflow
- VEC_DIV0, 32'd255: vector address, divide by zero

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- fetch_done  in  1  request PC <- PC+4 (select 000, ULA_out)
- branch_req  in  1  branch instruction resolved this cycle
- branch_taken  in  1  qualifies branch_req; select 001 (AluOut_out)
- jump_req  in  1  request jump (select 010, concatena_pc_out)
- rte_req  in  1  request return from exception (select 100, epc_out)
- exc_req  in  3  [0] invalid opcode, [1] overflow, [2] div-by-zero
- pc_source_sel  out  3  PC source mux control
- pc_write  out  1  PC load strobe
- epc_write  out  1  EPC load strobe
- mem_rd  out  1  memory read for vector fetch
- exc_vec_addr  out  32  vector address during mem_rd, else 0
- mdr_write  out  1  MDR load strobe
- exc_cause  out  2  0 opcode, 1 overflow, 2 div0; held until next exception
- busy  out  1  exception sequence in progress

## Operation
- All outputs registered. Reset: state IDLE, pc_source_sel=000, all strobes 0, exc_vec_addr=0, exc_cause=0, busy=0, wait counter 0.
- States: IDLE, EXC_SAVE, EXC_READ, EXC_LOAD, EXC_JUMP.
- IDLE, per edge, priority: exc_req != 0 > rte_req > jump_req > (branch_req & branch_taken) > fetch_done. Lower-priority requests in the same cycle are dropped.
- Non-exception request: next cycle pc_write=1 with matching pc_source_sel; stay IDLE. branch_req with branch_taken=0 produces no write.
- Exception: cause priority opcode > overflow > div0; exc_cause latched; go EXC_SAVE.
- EXC_SAVE: epc_write=1, busy=1 (datapath presents PC-4 to EPC). Next EXC_READ, counter cleared.
- EXC_READ: mem_rd=1, exc_vec_addr=vector for cause, for exactly MEM_WAIT cycles, then EXC_LOAD.
- EXC_LOAD: mdr_write=1 one cycle. Next EXC_JUMP.
- EXC_JUMP: pc_source_sel=011, pc_write=1 one cycle. Next IDLE, busy=0.
- While busy, all request inputs ignored (not queued).
- When no pc_write, pc_source_sel returns to 000.
- reset_n low at any point: immediate return to reset values; sequence abandoned.

## Timing
- Request sampled at edge N -> pc_write high during cycle N+1 only.
- Exception sampled at edge N: epc_write cycle N+1; mem_rd cycles N+2..N+1+MEM_WAIT; mdr_write cycle N+2+MEM_WAIT; pc_write (sel 011) cycle N+3+MEM_WAIT; busy high N+1..N+3+MEM_WAIT.
- Next request accepted at the edge ending the EXC_JUMP cycle is not allowed; first acceptable edge is the one after busy falls.
- Back-to-back non-exception requests: one pc_write per cycle.

## Configuration
- PC_UPDATE_EXC_EN defined: exception sequence and states EXC_* present as above.
- Undefined: exc_req ignored; epc_write, mem_rd, mdr_write, busy tied 0; exc_vec_addr and exc_cause tied 0; rte_req still supported.

## Test plan
- Reset mid-stream, then fetch_done=1 one cycle -> next cycle pc_write=1, pc_source_sel=000; all other outputs 0.
- Same cycle jump_req=1, branch_req=1, branch_taken=1, fetch_done=1 -> single pc_write with sel 010; branch_req=1, branch_taken=0 alone -> no pc_write.
- exc_req=3'b110, MEM_WAIT=2 -> exc_cause=1, epc_write at N+1, mem_rd with exc_vec_addr=254 at N+2,N+3, mdr_write N+4, pc_write sel 011 N+5, busy N+1..N+5.
- During busy, assert rte_req and fetch_done -> no extra pc_write; after busy falls, rte_req -> pc_write sel 100 next cycle.
- reset_n low during EXC_READ -> all outputs 0 immediately, state IDLE; fetch_done after release behaves normally.
- Build without PC_UPDATE_EXC_EN, exc_req=3'b001 -> no strobes, busy stays 0.
